vm_change_ctrl: RTL
===================

// Module: vm_change_ctrl
// PURPOSE
//   Change-payout sequencer for the vending machine. Accepts a change amount in coin
//   units (as produced by vm on its change output), then drives a coin hopper one
//   coin at a time over a req/ack handshake. Enforces an inter-coin gap and a
//   per-coin ack timeout, and reports completion or jam.
// PARAMETERS
//   CHG_W    3  width of the change amount and dispensed count (max 2^CHG_W-1 coins)
//   TIMEOUT  8  cycles hop_req may stay high without hop_ack before fault (>=2)
//   GAP      2  cycles hop_req is held low between consecutive coins (>=1)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   chg_valid  in   1      change request valid
//   chg_amt    in   CHG_W  coins to pay out; sampled when chg_valid & chg_ready
//   chg_ready  out  1      controller idle, can accept a request
//   hop_req    out  1      request hopper to eject one coin
//   hop_ack    in   1      hopper ejected the coin; sampled only in REQ
//   busy       out  1      payout in progress (REQ, GAP or DONE)
//   done       out  1      one-cycle pulse: payout complete
//   fault      out  1      hopper jam; held until fault_clr
//   fault_clr  in   1      clears fault, returns to IDLE
//   dispensed  out  CHG_W  coins ejected in current/last payout
// BEHAVIOUR
//   Reset: rst high at an edge forces IDLE. Next cycle: hop_req=0, busy=0, done=0,
//     fault=0, chg_ready=1, dispensed=0, remaining and timer = 0. Applies mid-payout;
//     coins already ejected are not re-counted.
//   FSM states: IDLE, REQ, GAP, DONE, FAULT. Outputs are decoded from registered state.
//   IDLE: chg_ready=1. On chg_valid at an edge: amt==0 -> DONE; else remaining=chg_amt,
//     dispensed=0, timer=0 -> REQ. Without chg_valid: stay in IDLE.
//   REQ: hop_req=1 from the cycle after acceptance. Each cycle: if hop_ack:
//     dispensed+1, remaining-1; then remaining was 1 -> DONE, else timer=0 -> GAP.
//     If no ack: timer+1; timer==TIMEOUT-1 without ack -> FAULT.
//     hop_req therefore stays high for at most TIMEOUT cycles.
//   Ack in the final timeout cycle counts. No fault is raised.
//   GAP: hop_req=0 for exactly GAP cycles, then -> REQ with timer=0.
//   DONE: done=1 and busy=1 for one cycle -> IDLE. dispensed holds until next accept.
//   FAULT: fault=1, hop_req=0, busy=0, chg_ready=0. dispensed holds the partial count.
//     fault_clr -> IDLE (remaining cleared). rst also clears it.
//   Ignored inputs: chg_valid outside IDLE; hop_ack outside REQ; fault_clr outside FAULT.
//   Timing: with hop_ack tied high, coin period = 1+GAP cycles. done rises one cycle
//     after the last ack. A payout of N coins is accept + N + (N-1)*GAP + 1 cycles.
//   Widths: remaining and dispensed are CHG_W bits and never wrap (dispensed<=chg_amt).
//     The timer is clog2(TIMEOUT) bits.
// TESTING (TIMEOUT=8, GAP=2)
//   1 Reset: rst=1 for 2 cycles, random inputs -> hop_req=0, busy=0, done=0, fault=0,
//     chg_ready=1, dispensed=0.
//   2 chg_amt=3, hop_ack=1 -> three 1-cycle hop_req pulses with 2 low cycles between.
//     done pulses the cycle after the 3rd, dispensed=3, chg_ready=1 after.
//   3 chg_amt=0 -> no hop_req, done=1 exactly one cycle after accept, dispensed=0.
//   4 chg_amt=2, hop_ack=0 -> hop_req high 8 cycles, then fault=1, dispensed=0.
//     chg_valid ignored; fault_clr=1 -> chg_ready=1 next cycle.
//   5 chg_amt=7, hop_ack=1, rst=1 after 2nd ack -> next cycle hop_req=0, busy=0,
//     dispensed=0. New chg_amt=1 then completes with dispensed=1.
//   6 chg_amt=2, ack delayed to 8th REQ cycle for coin 1 -> no fault, dispensed=1.
//     chg_valid pulses while busy are ignored; final dispensed=2.

Source files
------------

// File: rtl/vm_change_ctrl.sv
// ---------------------------------------------------------------------------
// vm_change_ctrl
//
// Change-payout sequencer for the vending machine. It takes a change amount
// in coin units and drives the coin hopper one coin at a time over a
// hop_req/hop_ack handshake. It holds hop_req low for a fixed gap between
// coins, raises a jam fault if the hopper does not acknowledge in time, and
// pulses done when the whole amount has been paid out.
//
// Parameters
//   CHG_W    width of the change amount and dispensed count
//   TIMEOUT  cycles hop_req may stay high without hop_ack before a jam (>=2)
//   GAP      cycles hop_req is held low between consecutive coins (>=1)
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   chg_valid  in   change request valid (only looked at while idle)
//   chg_amt    in   number of coins to pay out
//   chg_ready  out  controller idle and able to accept a request
//   hop_req    out  ask the hopper to eject one coin
//   hop_ack    in   hopper ejected the coin (only looked at while requesting)
//   busy       out  payout in progress (requesting, gap or done cycle)
//   done       out  one-cycle pulse when the payout is complete
//   fault      out  hopper jam, held until fault_clr
//   fault_clr  in   clears a jam and returns to idle
//   dispensed  out  coins ejected in the current or last payout
// ---------------------------------------------------------------------------
module vm_change_ctrl #(
   parameter int CHG_W   = 3,
   parameter int TIMEOUT = 8,
   parameter int GAP     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chg_valid,
   input  logic [CHG_W-1:0] chg_amt,
   output logic             chg_ready,
   output logic             hop_req,
   input  logic             hop_ack,
   output logic             busy,
   output logic             done,
   output logic             fault,
   input  logic             fault_clr,
   output logic [CHG_W-1:0] dispensed
);

   // The ack timer only has to count to TIMEOUT-1; the gap counter only to
   // GAP-1. Both are kept at least one bit wide so GAP=1 stays legal.
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [CHG_W-1:0] COIN_ONE = CHG_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_GAP,
      S_DONE,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CHG_W-1:0] remaining_q, remaining_d;
   logic [CHG_W-1:0] dispensed_q, dispensed_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   logic hop_req_q;
   logic busy_q;
   logic done_q;
   logic fault_q;
   logic chg_ready_q;

   // Next-state logic for the payout sequencer. Each state only listens to
   // the inputs that matter to it, so stray chg_valid, hop_ack or fault_clr
   // pulses in other states fall through to the hold defaults below.
   // A zero-coin request skips the hopper entirely and goes straight to the
   // done cycle. In the request state an ack always wins over the timeout,
   // so an ack arriving in the very last allowed cycle still counts.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      dispensed_d = dispensed_q;
      timer_d     = timer_q;
      gap_d       = gap_q;

      unique case (state_q)
         S_IDLE: begin
            if (chg_valid) begin
               dispensed_d = '0;
               timer_d     = '0;
               gap_d       = '0;
               if (chg_amt == '0) begin
                  remaining_d = '0;
                  state_d     = S_DONE;
               end else begin
                  remaining_d = chg_amt;
                  state_d     = S_REQ;
               end
            end
         end

         S_REQ: begin
            if (hop_ack) begin
               dispensed_d = dispensed_q + COIN_ONE;
               remaining_d = remaining_q - COIN_ONE;
               timer_d     = '0;
               if (remaining_q == COIN_ONE) begin
                  state_d = S_DONE;
               end else begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end
            end else if (timer_q == TMR_LAST) begin
               timer_d = '0;
               state_d = S_FAULT;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               timer_d = '0;
               state_d = S_REQ;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_FAULT: begin
            // dispensed keeps the partial count so the jam can be diagnosed.
            if (fault_clr) begin
               remaining_d = '0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers. The outputs are decoded from the next
   // state and registered alongside it, so they always match the registered
   // state exactly while staying glitch-free toward the hopper. Reset parks
   // the sequencer in idle with every counter cleared, even mid-payout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         dispensed_q <= '0;
         timer_q     <= '0;
         gap_q       <= '0;
         hop_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         chg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         dispensed_q <= dispensed_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
         hop_req_q   <= (state_d == S_REQ);
         busy_q      <= (state_d == S_REQ) || (state_d == S_GAP) || (state_d == S_DONE);
         done_q      <= (state_d == S_DONE);
         fault_q     <= (state_d == S_FAULT);
         chg_ready_q <= (state_d == S_IDLE);
      end
   end

   assign chg_ready = chg_ready_q;
   assign hop_req   = hop_req_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fault     = fault_q;
   assign dispensed = dispensed_q;

endmodule
